// File: rtl/chip8_disp_pkg.sv
// Shared definitions for the CHIP-8 display path: FSM states, command
// opcodes and framebuffer geometry helpers.
package chip8_disp_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FETCH,
      ST_FBR0,
      ST_WR0,
      ST_FBR1,
      ST_WR1,
      ST_NEXT,
      ST_CLEAR,
      ST_DONE
   } state_t;

   localparam logic OP_DRAW  = 1'b0;
   localparam logic OP_CLEAR = 1'b1;

   function automatic int calc_nwords(input int disp_w, input int disp_h, input int fb_word);
      return (disp_w * disp_h) / fb_word;
   endfunction

   function automatic int calc_wpr(input int disp_w, input int fb_word);
      return disp_w / fb_word;
   endfunction

   function automatic int calc_fb_aw(input int disp_w, input int disp_h, input int fb_word);
      return $clog2((disp_w * disp_h) / fb_word);
   endfunction

   localparam int NWORDS = calc_nwords(64, 32, 16);
   localparam int WPR    = calc_wpr(64, 16);
   localparam int FB_AW  = calc_fb_aw(64, 32, 16);

endpackage

// File: rtl/chip8_sprite_blitter_if.sv
// CPU-side command channel of the sprite blitter: request/ready handshake
// plus completion pulse and VF collision result.
interface chip8_sprite_blitter_if #(
   parameter int ADDR_W = 12
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_op;
   logic [7:0]        cmd_x;
   logic [7:0]        cmd_y;
   logic [3:0]        cmd_n;
   logic [ADDR_W-1:0] cmd_base;
   logic              done;
   logic              collision;

   modport master (
      output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_n, cmd_base,
      input  cmd_ready, done, collision
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_n, cmd_base,
      output cmd_ready, done, collision
   );
endinterface

// File: rtl/chip8_sprite_mask.sv
// Places one sprite byte at a pixel offset inside a two-word window and
// splits it into the masks for the left word and the following word.
module chip8_sprite_mask #(
   parameter  int FB_WORD = 16,
   parameter  int WRAP_EN = 0,
   localparam int OFF_W   = $clog2(FB_WORD)
) (
   input  logic [7:0]         i_byte,
   input  logic [OFF_W-1:0]   i_off,
   input  logic               i_last_word,
   output logic [FB_WORD-1:0] o_mask0,
   output logic [FB_WORD-1:0] o_mask1
);

   logic [2*FB_WORD-1:0] w_win;

   always_comb begin
      w_win   = {i_byte, {(2*FB_WORD-8){1'b0}}} >> i_off;
      o_mask0 = w_win[2*FB_WORD-1 -: FB_WORD];
      o_mask1 = w_win[FB_WORD-1:0];
      // Without wrap, pixels spilling past the right edge are dropped
      if (i_last_word && (WRAP_EN == 0)) begin
         o_mask1 = '0;
      end
   end

endmodule

// File: rtl/chip8_sprite_blitter.sv
// DXYN / 00E0 engine: fetches sprite rows, XORs them into a packed
// framebuffer RAM with read-modify-write, and reports the VF collision flag.
module chip8_sprite_blitter
   import chip8_disp_pkg::*;
#(
   parameter  int DISP_W  = 64,
   parameter  int DISP_H  = 32,
   parameter  int FB_WORD = 16,
   parameter  int ADDR_W  = 12,
   parameter  int WRAP_EN = 0,
   localparam int L_NW    = calc_nwords(DISP_W, DISP_H, FB_WORD),
   localparam int L_FB_AW = calc_fb_aw(DISP_W, DISP_H, FB_WORD),
   localparam int L_WPR   = calc_wpr(DISP_W, FB_WORD)
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset_n,
   chip8_sprite_blitter_if.slave cmd,
   output logic [ADDR_W-1:0]    mem_addr,
   input  logic [7:0]           mem_rdata,
   output logic [L_FB_AW-1:0]   fb_addr,
   output logic                 fb_re,
   input  logic [FB_WORD-1:0]   fb_rdata,
   output logic                 fb_we,
   output logic [FB_WORD-1:0]   fb_wdata
);

   localparam int OFF_W = $clog2(FB_WORD);

   state_t               r_state;
   state_t               w_next;
   logic [7:0]           r_x0;
   logic [7:0]           r_y0;
   logic [3:0]           r_n;
   logic [ADDR_W-1:0]    r_base;
   logic [4:0]           r_row;
   logic [FB_WORD-1:0]   r_mask0;
   logic [FB_WORD-1:0]   r_mask1;
   logic                 r_coll;
   logic [L_FB_AW-1:0]   r_clr_addr;

   logic                 w_accept;
   logic                 w_last;
   logic                 w_clip;
   logic [4:0]           w_row_inc;
   logic [L_FB_AW-1:0]   w_word0;
   logic [L_FB_AW-1:0]   w_word1;
   logic [FB_WORD-1:0]   w_mask0;
   logic [FB_WORD-1:0]   w_mask1;

   assign w_accept       = cmd.cmd_valid && (r_state == ST_IDLE);
   assign w_row_inc      = r_row + 5'd1;
   assign cmd.collision  = r_coll;

   // Word addresses of the current sprite row; the row index is always
   // reduced mod DISP_H, which only matters when wrapping is enabled.
   always_comb begin
      int unsigned v_col;
      int unsigned v_yrow;
      v_col   = 32'(r_x0) >> OFF_W;
      v_yrow  = (32'(r_y0) + 32'(r_row)) % DISP_H;
      w_last  = (v_col == 32'(L_WPR - 1));
      w_word0 = L_FB_AW'(v_yrow * L_WPR + v_col);
      w_word1 = w_last ? L_FB_AW'(v_yrow * L_WPR) : w_word0 + 1'b1;
      w_clip  = (WRAP_EN == 0) && ((32'(r_y0) + 32'(w_row_inc)) >= 32'(DISP_H));
   end

   chip8_sprite_mask #(
      .FB_WORD (FB_WORD),
      .WRAP_EN (WRAP_EN)
   ) u_mask (
      .i_byte      (mem_rdata),
      .i_off       (r_x0[OFF_W-1:0]),
      .i_last_word (w_last),
      .o_mask0     (w_mask0),
      .o_mask1     (w_mask1)
   );

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_state    <= ST_IDLE;
         r_x0       <= '0;
         r_y0       <= '0;
         r_n        <= '0;
         r_base     <= '0;
         r_row      <= '0;
         r_mask0    <= '0;
         r_mask1    <= '0;
         r_coll     <= 1'b0;
         r_clr_addr <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_x0       <= 8'(32'(cmd.cmd_x) % DISP_W);
                  r_y0       <= 8'(32'(cmd.cmd_y) % DISP_H);
                  r_n        <= cmd.cmd_n;
                  r_base     <= cmd.cmd_base;
                  r_row      <= '0;
                  r_coll     <= 1'b0;
                  r_clr_addr <= '0;
               end
            end
            ST_FBR0: begin
               r_mask0 <= w_mask0;
               r_mask1 <= w_mask1;
            end
            ST_WR0:  r_coll <= r_coll | (|(fb_rdata & r_mask0));
            ST_WR1:  r_coll <= r_coll | (|(fb_rdata & r_mask1));
            ST_NEXT: r_row <= w_row_inc;
            ST_CLEAR: r_clr_addr <= r_clr_addr + 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next        = r_state;
      cmd.cmd_ready = 1'b0;
      cmd.done      = 1'b0;
      mem_addr      = '0;
      fb_addr       = '0;
      fb_re         = 1'b0;
      fb_we         = 1'b0;
      fb_wdata      = '0;
      case (r_state)
         ST_IDLE: begin
            cmd.cmd_ready = 1'b1;
            if (cmd.cmd_valid) begin
               if (cmd.cmd_op == OP_CLEAR) w_next = ST_CLEAR;
               else if (cmd.cmd_n == 4'd0) w_next = ST_DONE;
               else                        w_next = ST_FETCH;
            end
         end
         ST_FETCH: begin
            mem_addr = r_base + ADDR_W'(r_row);
            w_next   = ST_FBR0;
         end
         ST_FBR0: begin
            fb_re   = 1'b1;
            fb_addr = w_word0;
            w_next  = ST_WR0;
         end
         ST_WR0: begin
            fb_we    = 1'b1;
            fb_addr  = w_word0;
            fb_wdata = fb_rdata ^ r_mask0;
            w_next   = (|r_mask1) ? ST_FBR1 : ST_NEXT;
         end
         ST_FBR1: begin
            fb_re   = 1'b1;
            fb_addr = w_word1;
            w_next  = ST_WR1;
         end
         ST_WR1: begin
            fb_we    = 1'b1;
            fb_addr  = w_word1;
            fb_wdata = fb_rdata ^ r_mask1;
            w_next   = ST_NEXT;
         end
         ST_NEXT: begin
            if ((w_row_inc == {1'b0, r_n}) || w_clip) w_next = ST_DONE;
            else                                      w_next = ST_FETCH;
         end
         ST_CLEAR: begin
            fb_we   = 1'b1;
            fb_addr = r_clr_addr;
            if (r_clr_addr == L_FB_AW'(L_NW - 1)) w_next = ST_DONE;
         end
         ST_DONE: begin
            cmd.done = 1'b1;
            w_next   = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_chip8_sprite_blitter.sv
// Drives a clipping and a wrapping blitter with identical commands and checks
// both against a pixel-level model of the CHIP-8 display.
module tb_chip8_sprite_blitter;
   import chip8_disp_pkg::*;

   localparam int W    = 64;
   localparam int H    = 32;
   localparam int F    = 16;
   localparam int AW   = 12;
   localparam int NW   = W * H / F;
   localparam int WPRL = W / F;
   localparam int FAW  = $clog2(NW);

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   chip8_sprite_blitter_if #(.ADDR_W(AW)) u_if0 ();
   chip8_sprite_blitter_if #(.ADDR_W(AW)) u_if1 ();

   logic [AW-1:0]  mem_addr  [2];
   logic [7:0]     mem_rdata [2];
   logic [FAW-1:0] fb_addr   [2];
   logic           fb_re     [2];
   logic           fb_we     [2];
   logic [F-1:0]   fb_rdata  [2];
   logic [F-1:0]   fb_wdata  [2];

   chip8_sprite_blitter #(
      .DISP_W(W), .DISP_H(H), .FB_WORD(F), .ADDR_W(AW), .WRAP_EN(0)
   ) u_dut_clip (
      .clk_clk(clk), .reset_reset_n(rst_n), .cmd(u_if0),
      .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0]),
      .fb_addr(fb_addr[0]), .fb_re(fb_re[0]), .fb_rdata(fb_rdata[0]),
      .fb_we(fb_we[0]), .fb_wdata(fb_wdata[0])
   );

   chip8_sprite_blitter #(
      .DISP_W(W), .DISP_H(H), .FB_WORD(F), .ADDR_W(AW), .WRAP_EN(1)
   ) u_dut_wrap (
      .clk_clk(clk), .reset_reset_n(rst_n), .cmd(u_if1),
      .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1]),
      .fb_addr(fb_addr[1]), .fb_re(fb_re[1]), .fb_rdata(fb_rdata[1]),
      .fb_we(fb_we[1]), .fb_wdata(fb_wdata[1])
   );

   // Sprite memory, framebuffer RAMs and activity counters
   logic [7:0]   smem [1<<AW];
   logic [F-1:0] seed [NW];
   logic [F-1:0] fbm  [2][NW];
   logic         load_seed = 1'b0;
   int unsigned  wr_cnt [2];
   int unsigned  rd_cnt [2];
   int unsigned  dual_err;

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         mem_rdata[i] <= smem[mem_addr[i]];
         if (fb_re[i]) begin
            fb_rdata[i] <= fbm[i][fb_addr[i]];
            rd_cnt[i]   <= rd_cnt[i] + 1;
         end
         if (fb_we[i]) begin
            fbm[i][fb_addr[i]] <= fb_wdata[i];
            wr_cnt[i]          <= wr_cnt[i] + 1;
         end
         if (load_seed) begin
            for (int k = 0; k < NW; k++) fbm[i][k] <= seed[k];
         end
      end
      if ((fb_re[0] && fb_we[0]) || (fb_re[1] && fb_we[1])) dual_err <= dual_err + 1;
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: one bit per pixel, per instance (0 = clip, 1 = wrap)
   bit pix [2][H][W];

   function automatic logic [F-1:0] model_word(input int i, input int w);
      logic [F-1:0] r;
      r = '0;
      for (int k = 0; k < F; k++) r[F-1-k] = pix[i][w / WPRL][(w % WPRL) * F + k];
      return r;
   endfunction

   function automatic int fb_diff(input int i);
      int d = 0;
      for (int w = 0; w < NW; w++) if (fbm[i][w] !== model_word(i, w)) d++;
      return d;
   endfunction

   task automatic model_clear(input int i);
      for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) pix[i][y][x] = 1'b0;
   endtask

   task automatic model_draw(input int i, input int x, input int y, input int n, input int base,
                             output int lat, output int nwr, output bit coll);
      int x0 = x % W;
      int y0 = y % H;
      int rows = 0;
      int strad = 0;
      coll = 1'b0;
      for (int r = 0; r < n; r++) begin
         int yy = y0 + r;
         logic [7:0] b;
         bit st = 1'b0;
         if (i == 0 && yy >= H) break;
         yy = yy % H;
         rows++;
         b = smem[(base + r) % (1 << AW)];
         for (int k = 0; k < 8; k++) begin
            int xx = x0 + k;
            if (!b[7-k]) continue;
            if (i == 0 && xx >= W) continue;
            if ((xx / F) != (x0 / F)) st = 1'b1;
            xx = xx % W;
            if (pix[i][yy][xx]) coll = 1'b1;
            pix[i][yy][xx] = ~pix[i][yy][xx];
         end
         if (st) strad++;
      end
      lat = 1 + 4 * rows + 2 * strad;
      nwr = rows + strad;
   endtask

   function automatic logic get_ready(input int i);
      return (i == 0) ? u_if0.cmd_ready : u_if1.cmd_ready;
   endfunction
   function automatic logic get_done(input int i);
      return (i == 0) ? u_if0.done : u_if1.done;
   endfunction
   function automatic logic get_coll(input int i);
      return (i == 0) ? u_if0.collision : u_if1.collision;
   endfunction

   task automatic set_valid(input int i, input logic v);
      if (i == 0) u_if0.cmd_valid = v;
      else        u_if1.cmd_valid = v;
   endtask

   task automatic set_cmd(input logic op, input int x, input int y, input int n, input int base);
      u_if0.cmd_op = op;          u_if1.cmd_op = op;
      u_if0.cmd_x = 8'(x);        u_if1.cmd_x = 8'(x);
      u_if0.cmd_y = 8'(y);        u_if1.cmd_y = 8'(y);
      u_if0.cmd_n = 4'(n);        u_if1.cmd_n = 4'(n);
      u_if0.cmd_base = AW'(base); u_if1.cmd_base = AW'(base);
   endtask

   task automatic check_idle(input string tag);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s.ready%0d", tag, i), 32'(get_ready(i)), 32'd1);
         check($sformatf("%s.done%0d", tag, i),  32'(get_done(i)),  32'd0);
         check($sformatf("%s.coll%0d", tag, i),  32'(get_coll(i)),  32'd0);
         check($sformatf("%s.we%0d", tag, i),    32'(fb_we[i]),     32'd0);
         check($sformatf("%s.re%0d", tag, i),    32'(fb_re[i]),     32'd0);
         check($sformatf("%s.maddr%0d", tag, i), 32'(mem_addr[i]),  32'd0);
      end
   endtask

   task automatic run_cmd(input logic op, input int x, input int y, input int n, input int base,
                          input bit hold, input string tag);
      int lat [2];
      int nwr [2];
      bit cexp [2];
      int done_at [2];
      logic cobs [2];
      int unsigned wr_s [2];
      int unsigned rd_s [2];
      for (int i = 0; i < 2; i++) begin
         wr_s[i] = wr_cnt[i];
         rd_s[i] = rd_cnt[i];
         done_at[i] = -1;
         cobs[i] = 1'bx;
         if (op == OP_CLEAR) begin
            model_clear(i);
            lat[i] = NW + 1; nwr[i] = NW; cexp[i] = 1'b0;
         end else begin
            model_draw(i, x, y, n, base, lat[i], nwr[i], cexp[i]);
         end
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) check($sformatf("%s.rdy_idle%0d", tag, i), 32'(get_ready(i)), 32'd1);
      set_cmd(op, x, y, n, base);
      set_valid(0, 1'b1);
      set_valid(1, 1'b1);
      for (int c = 1; c <= 1000; c++) begin
         @(negedge clk);
         if (c == 1) begin
            for (int i = 0; i < 2; i++) begin
               check($sformatf("%s.rdy_busy%0d", tag, i), 32'(get_ready(i)), 32'd0);
               if (!hold) set_valid(i, 1'b0);
            end
         end
         for (int i = 0; i < 2; i++) begin
            if (done_at[i] < 0 && get_done(i) === 1'b1) begin
               done_at[i] = c;
               cobs[i] = get_coll(i);
               set_valid(i, 1'b0);
            end
         end
         if (done_at[0] >= 0 && done_at[1] >= 0) break;
      end
      set_valid(0, 1'b0);
      set_valid(1, 1'b0);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s.lat%0d", tag, i),      32'(done_at[i]), 32'(lat[i]));
         check($sformatf("%s.coll%0d", tag, i),     32'(cobs[i]),    32'(cexp[i]));
         check($sformatf("%s.done_off%0d", tag, i), 32'(get_done(i)), 32'd0);
         check($sformatf("%s.rdy_back%0d", tag, i), 32'(get_ready(i)), 32'd1);
         check($sformatf("%s.coll_hold%0d", tag, i), 32'(get_coll(i)), 32'(cexp[i]));
         check($sformatf("%s.writes%0d", tag, i),   wr_cnt[i] - wr_s[i], 32'(nwr[i]));
         check($sformatf("%s.reads%0d", tag, i),    rd_cnt[i] - rd_s[i],
               (op == OP_CLEAR) ? 32'd0 : 32'(nwr[i]));
         check($sformatf("%s.fbstate%0d", tag, i),  32'(fb_diff(i)), 32'd0);
      end
   endtask

   initial begin
      u_if0.cmd_valid = 1'b0;
      u_if1.cmd_valid = 1'b0;
      set_cmd(OP_DRAW, 0, 0, 0, 0);
      for (int a = 0; a < (1 << AW); a++) smem[a] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      for (int w = 0; w < NW; w++) begin
         seed[w] = F'($urandom);
         for (int k = 0; k < F; k++) begin
            pix[0][w / WPRL][(w % WPRL) * F + k] = seed[w][F-1-k];
            pix[1][w / WPRL][(w % WPRL) * F + k] = seed[w][F-1-k];
         end
      end
      @(negedge clk);
      load_seed = 1'b1;
      @(negedge clk);
      load_seed = 1'b0;
      check_idle("por");
      @(negedge clk);
      rst_n = 1'b1;

      // Reset while the first row is being fetched: nothing written yet
      @(negedge clk);
      set_cmd(OP_DRAW, 12, 1, 3, 'h300);
      set_valid(0, 1'b1);
      set_valid(1, 1'b1);
      @(negedge clk);
      set_valid(0, 1'b0);
      set_valid(1, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_idle("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) check($sformatf("midrst.fb%0d", i), 32'(fb_diff(i)), 32'd0);

      run_cmd(OP_CLEAR, 0, 0, 0, 0, 1'b0, "clr1");

      smem['h200] = 8'hF0;
      run_cmd(OP_DRAW, 0, 0, 1, 'h200, 1'b0, "f0_a");
      check("f0_a.word0", 32'(fbm[0][0]), 32'h0000_F000);
      run_cmd(OP_DRAW, 0, 0, 1, 'h200, 1'b0, "f0_b");
      check("f0_b.word0", 32'(fbm[0][0]), 32'h0);

      smem['h210] = 8'hFF;
      run_cmd(OP_DRAW, 12, 1, 1, 'h210, 1'b0, "strad");
      check("strad.w4", 32'(fbm[0][4]), 32'h0000_000F);
      check("strad.w5", 32'(fbm[0][5]), 32'h0000_F000);

      run_cmd(OP_CLEAR, 0, 0, 0, 0, 1'b0, "clr2");
      smem['h220] = 8'hFF;
      smem['h221] = 8'hFF;
      run_cmd(OP_DRAW, 60, 31, 2, 'h220, 1'b0, "edge");
      check("edge.clip127", 32'(fbm[0][127]), 32'h0000_000F);
      check("edge.clip124", 32'(fbm[0][124]), 32'h0);
      check("edge.wrap127", 32'(fbm[1][127]), 32'h0000_000F);
      check("edge.wrap124", 32'(fbm[1][124]), 32'h0000_F000);
      check("edge.wrap3",   32'(fbm[1][3]),   32'h0000_000F);
      check("edge.wrap0",   32'(fbm[1][0]),   32'h0000_F000);

      run_cmd(OP_CLEAR, 0, 0, 0, 0, 1'b0, "clr3");
      smem['h230] = 8'hFF;
      run_cmd(OP_DRAW, 69, 33, 1, 'h230, 1'b1, "modbusy");
      check("modbusy.w4", 32'(fbm[0][4]), 32'h0000_07F8);

      run_cmd(OP_DRAW, 10, 10, 0, 'h240, 1'b0, "n0");

      for (int t = 0; t < 30; t++) begin
         if ($urandom_range(0, 9) == 0)
            run_cmd(OP_CLEAR, 0, 0, 0, 0, 1'b0, $sformatf("rclr%0d", t));
         else
            run_cmd(OP_DRAW, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 15),
                    $urandom_range(0, (1 << AW) - 1), $urandom_range(0, 1) == 1, $sformatf("rnd%0d", t));
      end

      check("strobe_excl", dual_err, 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/chip8_sprite_blitter.md
Name: chip8_sprite_blitter

Overview:
Hardware DXYN/00E0 engine for the next-generation vChip8 display path. It accepts draw and clear commands from the CPU side and fetches sprite bytes from CHIP-8 memory. Each sprite row is XOR-ed into a packed framebuffer RAM, and the block reports the VF collision flag. Resolution, framebuffer word width, address width and wrap/clip mode are parametrised, so the same block serves 64x32 and 128x64 (SCHIP) displays.

Parameters:
DISP_W, 64, display width in pixels; multiple of FB_WORD
DISP_H, 32, display height in pixels
FB_WORD, 16, framebuffer word width; power of 2, >= 8
ADDR_W, 12, CHIP-8 memory address width
WRAP_EN, 0, 0 = clip pixels past right/bottom edge; 1 = wrap toroidally
(derived) NWORDS = DISP_W*DISP_H/FB_WORD; FB_AW = clog2(NWORDS); WPR = DISP_W/FB_WORD

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid & cmd_ready
cmd_op  in  1  0 = draw, 1 = clear
cmd_x  in  8  sprite X (Vx)
cmd_y  in  8  sprite Y (Vy)
cmd_n  in  4  sprite rows
cmd_base  in  ADDR_W  sprite address (I)
mem_addr  out  ADDR_W  sprite byte read address; data returned 1 cycle later
mem_rdata  in  8  sprite byte
fb_addr  out  FB_AW  framebuffer word address
fb_re  out  1  framebuffer read strobe; fb_rdata valid next cycle
fb_rdata  in  FB_WORD  framebuffer read data
fb_we  out  1  framebuffer write strobe
fb_wdata  out  FB_WORD  framebuffer write data
done  out  1  one-cycle pulse at command completion
collision  out  1  VF result; valid with done, held until the next accept

Behaviour:
- Reset (asynchronous): state = IDLE. All outputs 0 except cmd_ready = 1. Framebuffer contents are not touched. Reset mid-command abandons the command; partial writes remain.
- Command capture: on accept, x0 = cmd_x mod DISP_W, y0 = cmd_y mod DISP_H, n, base. The collision accumulator is cleared. cmd_valid while busy is ignored (no queueing).
- Pixel mapping: word = y*WPR + x/FB_WORD. The word MSB is the leftmost pixel. Sprite bit 7 is the leftmost pixel.
- Masking: off = x0 mod FB_WORD. The byte is placed in a 2*FB_WORD window at bits [2F-1-off : 2F-8-off].
  - mask0 = upper half of the window, applied to word0 = row*WPR + x0/FB_WORD.
  - mask1 = lower half, applied to word1 = next word in the same row.
  - If word0 is the last word of the row: with WRAP_EN=1, word1 = first word of the row; with WRAP_EN=0, mask1 is forced to 0.
- FSM states:
  - IDLE: on accept, go to CLEAR if cmd_op = 1. If cmd_op = 0 and n = 0, go to DONE. Otherwise go to FETCH with row = 0.
  - FETCH: mem_addr = (base+row) mod 2^ADDR_W. Next: FBR0.
  - FBR0: latch mem_rdata, form masks, fb_re = 1, fb_addr = word0. Next: WR0.
  - WR0: fb_we = 1, fb_wdata = fb_rdata ^ mask0; collision |= |(fb_rdata & mask0). If mask1 != 0, go to FBR1, else NEXT.
  - FBR1: fb_re = 1, fb_addr = word1. Next: WR1.
  - WR1: write fb_rdata ^ mask1; collision update as in WR0. Next: NEXT.
  - NEXT: row++. Go to DONE if row == n. Also go to DONE if WRAP_EN = 0 and y0+row >= DISP_H (remaining rows clipped). With WRAP_EN = 1 the row index is (y0+row) mod DISP_H. Otherwise go to FETCH.
  - CLEAR: write 0 to addresses 0..NWORDS-1, one per cycle, then go to DONE with collision = 0.
  - DONE: done = 1 for one cycle, then IDLE.
- Latency (accept cycle = 0):
  - Draw: done in cycle 1 + 4*rows_drawn + 2*straddled_rows.
  - Clear: done in cycle NWORDS + 1.
- Only one of fb_re/fb_we is high per cycle. Writes happen only in WR0, WR1 and CLEAR.

Decomposition:
- Package chip8_disp_pkg: FSM state enum, cmd_op encodings (OP_DRAW, OP_CLEAR), and derived constants NWORDS, WPR, FB_AW.
- Sub-module chip8_sprite_mask: combinational (byte, off, last_word, WRAP_EN) -> mask0/mask1. It is unit-testable in isolation.

Test Plan:
1. Assert reset_reset_n = 0 mid-draw, then release -> cmd_ready = 1, done/fb_we/fb_re = 0, next command executes normally.
2. Clear (defaults) -> 128 writes, addr 0..127, data 0x0000; done in cycle 129; collision = 0.
3. Draw x=0, y=0, n=1, byte 0xF0 on a zero framebuffer -> write addr 0, data 0xF000, done in cycle 5, collision = 0. Repeat -> write 0x0000, collision = 1.
4. Straddle: x=12, y=1, byte 0xFF -> addr 4 XOR 0x000F, then addr 5 XOR 0xF000; done in cycle 7.
5. Edge case, x=60, y=31, n=2, bytes 0xFF:
   - WRAP_EN=0 -> only addr 127 XOR 0x000F; done in cycle 5.
   - WRAP_EN=1 -> addr 127 (0x000F), addr 124 (0xF000), addr 3 (0x000F), addr 0 (0xF000); done in cycle 13.
6. Coordinate modulo and busy: x=69, y=33 draws as x=5, y=1 (addr 4 mask 0x07F8). A second cmd_valid during the draw is ignored (cmd_ready = 0).
